// File: rtl/proc_gen.sv
// Simple multi-cycle processor: eight general registers, one ALU, one shared bus.
// Each instruction runs in T0..T3 under a two-process FSM; Done marks its last step.
module proc_gen #(
  parameter int unsigned N = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [N-1:0] BusWires,
  output logic         Z
);

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;
  typedef enum logic [2:0] {
    OpMv, OpMvi, OpAdd, OpSub, OpAnd, OpXor, OpMvnz, OpNop
  } op_e;

  state_e         state_q, state_d;
  logic [8:0]     ir_q;
  logic [N-1:0]   r_q [8];
  logic [N-1:0]   a_q, g_q, alu_res;
  logic           z_q;
  op_e            op;
  logic [2:0]     rx, ry;

  logic           ir_en, a_en, g_en, g_sel, din_sel;
  logic [7:0]     r_en, r_sel;

  assign op = op_e'(ir_q[8:6]);
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];
  assign Z  = z_q;

  always_comb begin
    state_d = state_q;
    Done    = 1'b0;
    ir_en   = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    g_sel   = 1'b0;
    din_sel = 1'b0;
    r_en    = 8'b0;
    r_sel   = 8'b0;
    unique case (state_q)
      StT0: begin
        if (Run) begin
          ir_en   = 1'b1;
          state_d = StT1;
        end
      end
      StT1: begin
        unique case (op)
          OpMv: begin
            r_sel   = 8'b1 << ry;
            r_en    = 8'b1 << rx;
            Done    = 1'b1;
            state_d = StT0;
          end
          OpMvi: begin
            din_sel = 1'b1;
            r_en    = 8'b1 << rx;
            Done    = 1'b1;
            state_d = StT0;
          end
          OpMvnz: begin
            r_sel   = 8'b1 << ry;
            // Z is the flag left by the most recent ALU instruction
            if (!z_q) r_en = 8'b1 << rx;
            Done    = 1'b1;
            state_d = StT0;
          end
          OpNop: begin
            Done    = 1'b1;
            state_d = StT0;
          end
          default: begin
            r_sel   = 8'b1 << rx;
            a_en    = 1'b1;
            state_d = StT2;
          end
        endcase
      end
      StT2: begin
        r_sel   = 8'b1 << ry;
        g_en    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        g_sel   = 1'b1;
        r_en    = 8'b1 << rx;
        Done    = 1'b1;
        state_d = StT0;
      end
      default: state_d = StT0;
    endcase
  end

  // AND-OR bus mux; DIN is also the idle value when nothing is selected.
  always_comb begin
    BusWires = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_sel[i]) BusWires = BusWires | r_q[i];
    end
    if (g_sel) BusWires = BusWires | g_q;
    if (din_sel || (r_sel == 8'b0 && !g_sel)) BusWires = BusWires | DIN;
  end

  always_comb begin
    unique case (op)
      OpAdd:   alu_res = a_q + BusWires;
      OpSub:   alu_res = a_q - BusWires;
      OpAnd:   alu_res = a_q & BusWires;
      OpXor:   alu_res = a_q ^ BusWires;
      default: alu_res = a_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StT0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (ir_en) ir_q <= DIN[N-1:N-9];
      if (a_en)  a_q  <= BusWires;
      if (g_en) begin
        g_q <= alu_res;
        z_q <= (alu_res == '0);
      end
      for (int i = 0; i < 8; i++) begin
        if (r_en[i]) r_q[i] <= BusWires;
      end
    end
  end

endmodule

// File: tb/tb_proc_gen.sv
// Directed bench for proc_gen: registers are observed on BusWires through mv rX,rX
// instructions, so every check goes through the top-level ports only.
module tb_proc_gen;

  localparam int unsigned N = 16;
  localparam logic [2:0] OpMv = 3'd0, OpMvi = 3'd1, OpAdd = 3'd2, OpSub = 3'd3;
  localparam logic [2:0] OpAnd = 3'd4, OpXor = 3'd5, OpMvnz = 3'd6, OpNop = 3'd7;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         Run;
  logic [N-1:0] DIN;
  logic [N-1:0] BusWires;
  logic         Done;
  logic         Z;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [N-1:0] last_bus;

  always #5 Clock = ~Clock;

  proc_gen #(.N(N)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .BusWires (BusWires),
    .Z        (Z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction from T0; counts steps until Done and captures the bus there.
  task automatic exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [N-1:0] imm, input int exp_steps, input string tag);
    int steps;
    bit seen;
    DIN = {op, rx, ry, {(N-9){1'b0}}};
    Run = 1'b1;
    @(negedge Clock);
    check({tag, ".t0done"}, 32'(Done), 32'd0);
    check({tag, ".t0bus"}, 32'(BusWires), 32'(DIN));
    @(posedge Clock);
    #1;
    Run   = 1'b0;
    DIN   = imm;
    steps = 1;
    seen  = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge Clock);
      if (Done) begin
        seen     = 1'b1;
        last_bus = BusWires;
      end else begin
        @(posedge Clock);
        #1;
        steps++;
      end
    end
    check({tag, ".steps"}, seen ? 32'(steps) : 32'd99, 32'(exp_steps));
    @(posedge Clock);
    #1;
    DIN = '0;
  endtask

  task automatic read_reg(input logic [2:0] r, input logic [N-1:0] exp, input string tag);
    exec(OpMv, r, r, '0, 1, {tag, ".rd"});
    check(tag, 32'(last_bus), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 16'h1234;
    #2;
    check("rst.done", 32'(Done), 32'd0);
    check("rst.z", 32'(Z), 32'd0);
    check("rst.bus_din", 32'(BusWires), 32'h1234);
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    exec(OpMvi, 3'd0, 3'd0, 16'h0005, 1, "mvi_r0");
    check("mvi_r0.bus", 32'(last_bus), 32'h0005);
    exec(OpMvi, 3'd1, 3'd0, 16'h0003, 1, "mvi_r1");
    read_reg(3'd0, 16'h0005, "r0_5");
    read_reg(3'd1, 16'h0003, "r1_3");

    exec(OpAdd, 3'd0, 3'd1, '0, 3, "add_r0r1");
    check("add_r0r1.g", 32'(last_bus), 32'h0008);
    check("add_r0r1.z", 32'(Z), 32'd0);
    read_reg(3'd0, 16'h0008, "r0_8");

    exec(OpSub, 3'd1, 3'd1, '0, 3, "sub_r1r1");
    check("sub_r1r1.z", 32'(Z), 32'd1);
    read_reg(3'd1, 16'h0000, "r1_0");
    check("mv_keeps_z", 32'(Z), 32'd1);

    exec(OpMvnz, 3'd2, 3'd0, '0, 1, "mvnz_z1");
    read_reg(3'd2, 16'h0000, "r2_unch");
    exec(OpAdd, 3'd0, 3'd0, '0, 3, "add_r0r0");
    check("add_r0r0.z", 32'(Z), 32'd0);
    exec(OpMvnz, 3'd2, 3'd0, '0, 1, "mvnz_z0");
    read_reg(3'd2, 16'h0010, "r2_10");

    exec(OpMvi, 3'd3, 3'd0, 16'hFFFF, 1, "mvi_r3");
    exec(OpMvi, 3'd0, 3'd0, 16'h0001, 1, "mvi_r0_1");
    exec(OpAdd, 3'd3, 3'd0, '0, 3, "add_wrap");
    check("add_wrap.z", 32'(Z), 32'd1);
    read_reg(3'd3, 16'h0000, "r3_wrap");

    // Idle in T0 with an ALU word on DIN: nothing may be accepted.
    DIN = {OpAdd, 3'd3, 3'd3, 7'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("idle.done", 32'(Done), 32'd0);
      check("idle.bus", 32'(BusWires), 32'(DIN));
      @(posedge Clock);
      #1;
    end
    check("idle.z", 32'(Z), 32'd1);
    read_reg(3'd0, 16'h0001, "idle_r0");
    read_reg(3'd3, 16'h0000, "idle_r3");

    exec(OpAdd, 3'd0, 3'd0, '0, 3, "add_r0_2");
    check("add_r0_2.z", 32'(Z), 32'd0);
    exec(OpMvi, 3'd4, 3'd0, 16'hA5A5, 1, "mvi_r4");
    exec(OpXor, 3'd4, 3'd4, '0, 3, "xor_r4r4");
    check("xor_r4r4.z", 32'(Z), 32'd1);
    read_reg(3'd4, 16'h0000, "r4_0");
    exec(OpNop, 3'd0, 3'd0, '0, 1, "nop_z1");
    check("nop_z1.z", 32'(Z), 32'd1);
    exec(OpAdd, 3'd0, 3'd0, '0, 3, "add_r0_4");
    exec(OpNop, 3'd5, 3'd6, '0, 1, "nop_z0");
    check("nop_z0.z", 32'(Z), 32'd0);
    read_reg(3'd0, 16'h0004, "r0_4");

    exec(OpMvi, 3'd5, 3'd0, 16'h0F0F, 1, "mvi_r5");
    exec(OpMvi, 3'd6, 3'd0, 16'h00FF, 1, "mvi_r6");
    exec(OpAnd, 3'd5, 3'd6, '0, 3, "and_r5r6");
    read_reg(3'd5, 16'h000F, "r5_and");
    exec(OpXor, 3'd6, 3'd5, '0, 3, "xor_r6r5");
    read_reg(3'd6, 16'h00F0, "r6_xor");
    exec(OpSub, 3'd5, 3'd6, '0, 3, "sub_borrow");
    check("sub_borrow.z", 32'(Z), 32'd0);
    read_reg(3'd5, 16'hFF1F, "r5_sub");
    exec(OpMvi, 3'd7, 3'd7, 16'h1234, 1, "mvi_r7r7");
    read_reg(3'd7, 16'h1234, "r7_mvi");
    exec(OpSub, 3'd4, 3'd4, '0, 3, "sub_z1");

    // Abort an add in T2 with reset; nothing may be written afterwards.
    DIN = {OpAdd, 3'd0, 3'd5, 7'b0};
    Run = 1'b1;
    @(posedge Clock);
    #1;
    Run = 1'b0;
    DIN = '0;
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    check("abort.done", 32'(Done), 32'd0);
    check("abort.z", 32'(Z), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    check("abort.done_hold", 32'(Done), 32'd0);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), 16'h0000, $sformatf("abort_r%0d", r));
    end
    check("abort.z_after", 32'(Z), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/proc_gen.md
PROC_GEN -- requirements
Module: proc_gen

Interface
REQ-001 Parameter N, default 16: datapath, register, bus and DIN width; N SHALL be >= 9.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 DIN  input  N  instruction word in T0; immediate data in T1 of mvi.
REQ-005 Run  input  1  start request, sampled in T0 only.
REQ-006 Done  output  1  combinational; high in the final time step of each instruction.
REQ-007 BusWires  output  N  internal bus value.
REQ-008 Z  output  1  zero flag, registered.

Function
REQ-009 Instruction word SHALL be DIN[N-1:N-3]=opcode III, DIN[N-4:N-6]=rX, DIN[N-7:N-9]=rY; DIN[N-10:0] ignored.
REQ-010 Opcodes SHALL be: 000 mv rX<-rY; 001 mvi rX<-DIN; 010 add; 011 sub; 100 and; 101 xor; 110 mvnz (rX<-rY if Z==0); 111 nop.
REQ-011 Eight general registers R0..R7, plus A, G and IR, SHALL each be N bits wide; IR SHALL hold the upper 9 bits of the instruction word only.
REQ-012 The FSM SHALL have states T0, T1, T2, T3, held in a 2-bit register.
REQ-013 T0: IR SHALL load when Run=1, with next state T1; with Run=0, IR SHALL hold and the state SHALL stay T0.
REQ-014 T1 for mv, mvi, mvnz and nop: Done=1, next state T0.
REQ-015 T1 for add/sub/and/xor: A<-rX, next state T2; the bus SHALL carry rX.
REQ-016 T2: G<-A op rY and Z<-(result==0), both loaded on the same edge, next state T3.
REQ-017 T3: rX<-G with G driven on the bus, Done=1, next state T0.
REQ-018 Arithmetic SHALL be modulo 2^N; carry and borrow SHALL be discarded; sub SHALL compute A minus rY.
REQ-019 and/xor SHALL be bitwise over all N bits.
REQ-020 mvnz with Z=1 SHALL write no register but still assert Done in T1.
REQ-021 Z SHALL change only in T2 of an ALU instruction; mv, mvi, mvnz and nop SHALL leave Z unchanged.
REQ-022 The bus mux SHALL use one-hot select over {R0..R7, G, DIN}; with no select active, the bus SHALL carry DIN.
REQ-023 mvi with rX=rY SHALL still write DIN to rX.
REQ-024 ALU ops with rX=rY SHALL use the same register as both operands: sub gives 0 and Z=1; xor gives 0.
REQ-025 A register SHALL load only when its enable is active on a rising Clock edge.
REQ-026 Run is ignored outside T0; an instruction in progress SHALL always run to completion.
REQ-027 Done SHALL be low in T0 and T2, and in T1 of ALU instructions.

Reset
REQ-028 Resetn=0 SHALL immediately force state T0 and clear R0..R7, A, G, IR and Z to 0, regardless of Clock.
REQ-029 Reset asserted mid-instruction SHALL abort it with no register write after the reset edge; Done SHALL read 0 while Resetn=0.
REQ-030 After Resetn rises, the first instruction SHALL be accepted on the first edge with Run=1 in T0.

Verification
REQ-031 Reset pulse during T2 of an add -> state T0, all registers 0, Z=0, Done=0.
REQ-032 With N=16: mvi R0,#5 then mvi R1,#3 -> R0=0x0005 and R1=0x0003, each with Done in T1 (2 cycles per instruction).
REQ-033 add R0,R1 -> Done in T3, R0=0x0008, Z=0; then sub R1,R1 -> R1=0, Z=1.
REQ-034 mvnz R2,R0 with Z=1 -> R2 unchanged; after add R0,R0 (Z=0), mvnz R2,R0 -> R2=0x0010.
REQ-035 mvi R3,#0xFFFF then add R3,R0 (R0=0x0001) -> R3=0x0000, Z=1 (wrap-around).
REQ-036 Run=0 for 5 cycles in T0 -> state, IR and registers unchanged; xor R4,R4 -> R4=0, Z=1; nop -> Z unchanged.
